// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_pkg
// Brief    : RV32I opcodes, instruction field positions and decode helpers.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OP_IMM      = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OP_STORE    = 7'b0100011;
    localparam logic [6:0] c_OP_REG      = 7'b0110011;
    localparam logic [6:0] c_OP_LUI      = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OP_JALR     = 7'b1100111;
    localparam logic [6:0] c_OP_JAL      = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM   = 7'b1110011;

    localparam int c_REG_BITS     = 5;
    localparam int c_OPCODE_LSB   = 0;
    localparam int c_RD_LSB       = 7;
    localparam int c_FUNCT3_LSB   = 12;
    localparam int c_RS1_LSB      = 15;
    localparam int c_RS2_LSB      = 20;
    localparam int c_FUNCT7B5_BIT = 30;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e fmt;
        logic     writes_rd;
        logic     illegal;
    } dec_ctrl_t;

    // writes_rd is the format-level property; the rd != 0 gate is applied by the caller.
    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode);
        dec_ctrl_t c;
        c.fmt       = IMM_NONE;
        c.writes_rd = 1'b0;
        c.illegal   = 1'b0;
        case (opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM: begin
                c.fmt       = IMM_I;
                c.writes_rd = 1'b1;
            end
            c_OP_STORE:            c.fmt = IMM_S;
            c_OP_BRANCH:           c.fmt = IMM_B;
            c_OP_LUI, c_OP_AUIPC: begin
                c.fmt       = IMM_U;
                c.writes_rd = 1'b1;
            end
            c_OP_JAL: begin
                c.fmt       = IMM_J;
                c.writes_rd = 1'b1;
            end
            c_OP_REG:              c.writes_rd = 1'b1;
            c_OP_MISC_MEM:         c.fmt = IMM_NONE;
            default:               c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational RV32 immediate builder, sign-extended from bit 31.
// Revision : 1.0
// ============================================================================
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32 decode: register-file addressing, writeback forwarding, ID/EX register.
// Revision : 1.0
// ============================================================================
module decode_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic             id_ready,
    input  logic             flush,
    output logic [AW-1:0]    rf_regA,
    output logic [AW-1:0]    rf_regB,
    input  logic [WIDTH-1:0] rf_portA,
    input  logic [WIDTH-1:0] rf_portB,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_rs1_data,
    output logic [WIDTH-1:0] ex_rs2_data,
    output logic [WIDTH-1:0] ex_imm,
    output logic [AW-1:0]    ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_reg_write,
    output logic             ex_illegal
);

    logic             w_load;
    dec_ctrl_t        w_ctrl;
    logic [AW-1:0]    w_rd;
    logic             w_reg_write;
    logic [31:0]      w_imm;

    logic             r_valid;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_imm;
    logic [AW-1:0]    r_rd;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic             r_reg_write;
    logic             r_illegal;
    logic [AW-1:0]    r_rs1;
    logic [AW-1:0]    r_rs2;
    logic             r_fwd_va;
    logic             r_fwd_vb;
    logic [WIDTH-1:0] r_fwd_da;
    logic [WIDTH-1:0] r_fwd_db;

    assign id_ready    = !r_valid || ex_ready;
    assign w_load      = if_valid && id_ready && !flush;
    assign w_ctrl      = decode_ctrl(if_instr[c_OPCODE_LSB +: 7]);
    assign w_rd        = if_instr[c_RD_LSB +: c_REG_BITS];
    assign w_reg_write = w_ctrl.writes_rd && (w_rd != '0);

    imm_gen u_imm_gen (
        .instr (if_instr[31:7]),
        .fmt   (w_ctrl.fmt),
        .imm   (w_imm)
    );

    // While stalled the held rs addresses are re-presented so the file keeps re-reading.
    assign rf_regA = w_load ? if_instr[c_RS1_LSB +: c_REG_BITS] : r_rs1;
    assign rf_regB = w_load ? if_instr[c_RS2_LSB +: c_REG_BITS] : r_rs2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7b5  <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_fwd_va    <= 1'b0;
            r_fwd_vb    <= 1'b0;
            r_fwd_da    <= '0;
            r_fwd_db    <= '0;
        end else begin
            // The file returns pre-write data on a same-edge write; capture it here instead.
            r_fwd_va <= wb_en && (wb_rd != '0) && (wb_rd == rf_regA);
            r_fwd_vb <= wb_en && (wb_rd != '0) && (wb_rd == rf_regB);
            r_fwd_da <= wb_data;
            r_fwd_db <= wb_data;

            if (flush)
                r_valid <= 1'b0;
            else if (w_load)
                r_valid <= 1'b1;
            else if (ex_ready)
                r_valid <= 1'b0;

            if (w_load) begin
                r_pc        <= if_pc;
                r_imm       <= w_imm;
                r_rd        <= w_reg_write ? w_rd : '0;
                r_opcode    <= if_instr[c_OPCODE_LSB +: 7];
                r_funct3    <= if_instr[c_FUNCT3_LSB +: 3];
                r_funct7b5  <= if_instr[c_FUNCT7B5_BIT];
                r_reg_write <= w_reg_write;
                r_illegal   <= w_ctrl.illegal;
                r_rs1       <= if_instr[c_RS1_LSB +: c_REG_BITS];
                r_rs2       <= if_instr[c_RS2_LSB +: c_REG_BITS];
            end
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_imm       = r_imm;
    assign ex_rd        = r_rd;
    assign ex_opcode    = r_opcode;
    assign ex_funct3    = r_funct3;
    assign ex_funct7b5  = r_funct7b5;
    assign ex_reg_write = r_reg_write;
    assign ex_illegal   = r_illegal;

    // Operands are zeroed without a valid bundle so reset leaves every ex_* output at 0.
    assign ex_rs1_data = !r_valid ? '0 : (r_fwd_va ? r_fwd_da : rf_portA);
    assign ex_rs2_data = !r_valid ? '0 : (r_fwd_vb ? r_fwd_db : rf_portB);

endmodule
`default_nettype wire
